// File: rtl/zwait_service.sv
// Servicing end of the Z80 WAIT protocol: arbitrates synchronized WAIT flags, posts one source to
// the service processor, issues the wait_end release pulse and checks that the flag drops.
module zwait_service #(
  parameter int unsigned END_LEN  = 4,
  parameter int unsigned DRAIN_TO = 255
) (
  input  logic       fclk,
  input  logic       rst,
  input  logic [6:0] waits_in,
  output logic       svc_req,
  output logic [2:0] svc_src,
  input  logic       svc_ack,
  output logic       wait_end,
  output logic       busy,
  output logic       to_err,
  input  logic       err_clr
);

  localparam logic [7:0] EndLoad   = 8'(END_LEN - 1);
  localparam logic [7:0] DrainLoad = 8'(DRAIN_TO - 1);

  typedef enum logic [2:0] {StIdle, StPend, StEnd, StDrain, StGuard} state_e;

  state_e     r_state;
  logic [6:0] r_sync1;
  logic [6:0] r_ws;
  logic [2:0] r_src;
  logic [7:0] r_cnt;
  logic       r_req;
  logic       r_wait_end;
  logic       r_busy;
  logic       r_err;

  logic [2:0] w_pick;
  logic       w_any;
  logic       w_flag;

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_ws    <= '0;
    end else begin
      r_sync1 <= waits_in;
      r_ws    <= r_sync1;
    end
  end

  // Descending scan so the lowest set index is the one left standing.
  always_comb begin
    w_pick = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (r_ws[i]) w_pick = 3'(i);
    end
  end

  assign w_any  = |r_ws;
  assign w_flag = |(r_ws & (7'd1 << r_src));

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_src      <= 3'd0;
      r_cnt      <= 8'd0;
      r_req      <= 1'b0;
      r_wait_end <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      // A timeout set further down overrides this clear when both land together.
      if (err_clr) r_err <= 1'b0;

      unique case (r_state)
        StIdle: begin
          if (w_any) begin
            r_src   <= w_pick;
            r_req   <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= StPend;
          end
        end
        StPend: begin
          if (!w_flag) begin
            r_req   <= 1'b0;
            r_state <= StGuard;
          end else if (svc_ack) begin
            r_req      <= 1'b0;
            r_wait_end <= 1'b1;
            r_cnt      <= EndLoad;
            r_state    <= StEnd;
          end
        end
        StEnd: begin
          if (r_cnt == 8'd0) begin
            r_wait_end <= 1'b0;
            r_cnt      <= DrainLoad;
            r_state    <= StDrain;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        StDrain: begin
          if (!w_flag) begin
            r_state <= StGuard;
          end else if (r_cnt == 8'd0) begin
            r_err   <= 1'b1;
            r_state <= StGuard;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        StGuard: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_req      <= 1'b0;
          r_wait_end <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= StIdle;
        end
      endcase
    end
  end

  assign svc_req  = r_req;
  assign svc_src  = r_src;
  assign wait_end = r_wait_end;
  assign busy     = r_busy;
  assign to_err   = r_err;

endmodule

// File: tb/tb_zwait_service.sv
// Bench for zwait_service: directed scenarios plus randomized flag patterns checked against
// transaction-level expectations (lowest-index pick, pulse width, abort and timeout rules).
module tb_zwait_service;

  localparam int unsigned EndLen  = 4;
  localparam int unsigned DrainTo = 8;

  logic       fclk;
  logic       rst;
  logic [6:0] waits_in;
  logic       svc_req;
  logic [2:0] svc_src;
  logic       svc_ack;
  logic       wait_end;
  logic       busy;
  logic       to_err;
  logic       err_clr;

  logic [6:0] flags;
  int         n_checks;
  int         n_err;

  zwait_service #(
    .END_LEN (EndLen),
    .DRAIN_TO(DrainTo)
  ) dut (
    .fclk    (fclk),
    .rst     (rst),
    .waits_in(waits_in),
    .svc_req (svc_req),
    .svc_src (svc_src),
    .svc_ack (svc_ack),
    .wait_end(wait_end),
    .busy    (busy),
    .to_err  (to_err),
    .err_clr (err_clr)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input logic [6:0] f);
    for (int i = 0; i < 7; i++) if (f[i]) return i;
    return 0;
  endfunction

  task automatic pulse_ack();
    svc_ack = 1'b1;
    @(negedge fclk);
    svc_ack = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin
      @(negedge fclk);
      n++;
    end
    chk(tag, busy, 0);
  endtask

  task automatic wait_req(input string tag, input int bound);
    int n;
    n = 0;
    while (!svc_req && n < bound) begin
      @(negedge fclk);
      n++;
    end
    chk(tag, svc_req, 1);
  endtask

  // Services the currently driven flags once; flags[src] is cleared by the end of the pass.
  task automatic do_pass(input bit abort, input bit simul, input bit drain_ack, input bit freeze,
                         input int drop_dly);
    int exp_src;
    int n;
    logic hi;
    exp_src = lowest(flags);
    wait_req("req_seen", 8);
    chk("src_pick", svc_src, exp_src);
    chk("busy_pend", busy, 1);
    if (freeze && exp_src != 0) begin
      flags[0] = 1'b1;
      waits_in = flags;
      repeat (4) @(negedge fclk);
      chk("src_frozen", svc_src, exp_src);
      chk("req_hold", svc_req, 1);
    end
    if (abort) begin
      hi = 1'b0;
      flags[exp_src] = 1'b0;
      waits_in = flags;
      repeat (2) begin
        @(negedge fclk);
        hi = hi | wait_end;
      end
      // Ack lands on the same edge the synchronized withdrawal is first seen.
      if (simul) svc_ack = 1'b1;
      @(negedge fclk);
      svc_ack = 1'b0;
      hi = hi | wait_end;
      n = 0;
      while (busy && n < 10) begin
        @(negedge fclk);
        hi = hi | wait_end;
        n++;
      end
      chk("abort_no_end", hi, 0);
      chk("abort_idle", busy, 0);
    end else begin
      pulse_ack();
      chk("req_drop", svc_req, 0);
      n = 0;
      while (wait_end && n < 20) begin
        @(negedge fclk);
        n++;
      end
      chk("end_len", n, EndLen);
      if (drain_ack) begin
        pulse_ack();
        chk("drain_ack_end", wait_end, 0);
        chk("drain_ack_busy", busy, 1);
      end else begin
        repeat (drop_dly) @(negedge fclk);
      end
      flags[exp_src] = 1'b0;
      waits_in = flags;
      wait_idle("drain_idle", 12);
      chk("no_err", to_err, 0);
      chk("idle_end_low", wait_end, 0);
    end
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_err    = 0;
    rst      = 1'b1;
    waits_in = '0;
    flags    = '0;
    svc_ack  = 1'b0;
    err_clr  = 1'b0;
    repeat (3) @(negedge fclk);
    chk("rst_req", svc_req, 0);
    chk("rst_src", svc_src, 0);
    chk("rst_end", wait_end, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", to_err, 0);
    rst = 1'b0;
    repeat (2) @(negedge fclk);
    chk("post_rst_busy", busy, 0);

    // Single source: latency, then a clean service.
    flags = 7'h01;
    waits_in = flags;
    n = 0;
    while (!svc_req && n < 6) begin
      @(negedge fclk);
      n++;
    end
    chk("latency_1", n <= 3, 1);
    do_pass(0, 0, 0, 0, 1);

    // Two sources: bit1 first, then bit2 on a second pass.
    flags = 7'h06;
    waits_in = flags;
    do_pass(0, 0, 0, 0, 0);
    do_pass(0, 0, 0, 0, 2);

    // Withdrawal before ack, then withdrawal coincident with ack.
    flags = 7'h01;
    waits_in = flags;
    do_pass(1, 0, 0, 0, 0);
    flags = 7'h01;
    waits_in = flags;
    do_pass(1, 1, 0, 0, 0);

    // Ack in IDLE changes nothing.
    pulse_ack();
    repeat (3) @(negedge fclk);
    chk("idle_ack_busy", busy, 0);
    chk("idle_ack_end", wait_end, 0);
    chk("idle_ack_req", svc_req, 0);

    // Ack in DRAIN is ignored.
    flags = 7'h10;
    waits_in = flags;
    do_pass(0, 0, 1, 0, 0);

    // Drain timeout with the flag held.
    flags = 7'h01;
    waits_in = flags;
    wait_req("to_req", 8);
    pulse_ack();
    n = 0;
    while (wait_end && n < 20) begin
      @(negedge fclk);
      n++;
    end
    chk("to_end_len", n, EndLen);
    n = 0;
    while (!to_err && n < 20) begin
      @(negedge fclk);
      n++;
    end
    chk("to_cycles", n, DrainTo);
    wait_idle("to_idle", 5);
    wait_req("to_rearb", 6);
    chk("to_rearb_src", svc_src, 0);
    chk("to_sticky", to_err, 1);
    err_clr = 1'b1;
    @(negedge fclk);
    err_clr = 1'b0;
    chk("err_clr", to_err, 0);

    // Second timeout with err_clr held throughout: the set must win.
    pulse_ack();
    n = 0;
    while (wait_end && n < 20) begin
      @(negedge fclk);
      n++;
    end
    err_clr = 1'b1;
    n = 0;
    while (!to_err && n < 20) begin
      @(negedge fclk);
      n++;
    end
    chk("set_wins", n, DrainTo);
    err_clr = 1'b0;
    @(negedge fclk);
    chk("err_after_set", to_err, 1);
    err_clr = 1'b1;
    @(negedge fclk);
    err_clr = 1'b0;
    chk("err_clr2", to_err, 0);
    do_pass(0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of the release pulse.
    flags = 7'h08;
    waits_in = flags;
    wait_req("rst_mid_req", 8);
    pulse_ack();
    @(negedge fclk);
    chk("rst_mid_pre", wait_end, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_end", wait_end, 0);
    chk("rst_mid_req", svc_req, 0);
    chk("rst_mid_busy", busy, 0);
    flags = '0;
    waits_in = flags;
    @(negedge fclk);
    rst = 1'b0;
    repeat (3) @(negedge fclk);
    chk("rst_mid_after", busy, 0);

    // Randomized patterns, each drained completely one source per pass.
    for (int it = 0; it < 25; it++) begin
      flags = 7'($urandom_range(1, 127));
      waits_in = flags;
      n = 0;
      while (!svc_req && n < 6) begin
        @(negedge fclk);
        n++;
      end
      chk("rnd_latency", n <= 3, 1);
      while (flags != 0) begin
        bit ab;
        ab = ($urandom_range(0, 3) == 0);
        do_pass(ab, ab && $urandom_range(0, 1) == 1, !ab && $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 2));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
